fc_out_serializer: RTL and testbench

Output stage for the fully-connected layer datapath (`fc_<M>_<N>_<T>_<P>_<R>` family). It accepts one completed vector of N wide signed accumulator results in a single parallel handshake. It saturates each result to T bits, optionally applies ReLU, and transmits the N values one per handshake on the layer's `output_valid`/`output_ready`/`output_data` stream. This is the transmitting end of the same stream that layer testbenches consume with randomized `output_ready`.

---
 rtl/fc_out_serializer.sv | 126 ++++++++++++
 tb/tb_fc_out_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_out_serializer.sv
// fc_out_serializer: output stage of the fully-connected layer datapath.
// Takes one vector of N signed ACCW-bit accumulators in a single parallel
// handshake. Each element is saturated to T bits (and ReLU-clamped when the
// FC_OUT_RELU_EN macro is defined). The N words then go out one per
// handshake, element 0 first.
//
// Handshake semantics (both ports): a transfer happens at a rising edge
// where valid && ready are both high. The sender holds valid and data
// stable until that edge. ready may depend on the other port, but valid
// never depends on ready. load_ready is the only combinational
// input-to-output path: output_ready -> load_ready, so a new vector can
// land on the same edge as the last word leaves, with no bubble.
//
// Configuration macro: FC_OUT_RELU_EN (undefined by default).
module fc_out_serializer #(
  parameter int T    = 16,
  parameter int N    = 8,
  parameter int ACCW = 36
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [N*ACCW-1:0] load_data,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [T-1:0]      output_data
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [T-1:0]  buf_q [N];

  // Handshake decode, visible to checkers.
  logic out_fire;
  logic last_word;
  logic load_fire;

  // Clamp one accumulator to the signed T-bit range. The value fits when
  // every bit from T-1 upward equals the sign bit. Otherwise the sign of
  // the full-width value picks which rail to use.
  function automatic logic [T-1:0] saturate(input logic [ACCW-1:0] v);
    logic [ACCW-T:0] top;
    logic [T-1:0]    r;
    top = v[ACCW-1:T-1];
    if (top == '0 || top == '1) begin
      r = v[T-1:0];
    end else if (v[ACCW-1]) begin
      r = {1'b1, {(T-1){1'b0}}};
    end else begin
      r = {1'b0, {(T-1){1'b1}}};
    end
`ifdef FC_OUT_RELU_EN
    if (r[T-1]) begin
      r = '0;
    end
`endif
    return r;
  endfunction

  // Decode both handshakes for the current cycle.
  always_comb begin
    last_word = (idx_q == LAST_IDX);
    out_fire  = (state_q == SEND) && output_ready;
    load_fire = load_valid && ((state_q == IDLE) || (out_fire && last_word));
  end

  // FSM state and word index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state. A load wins over end-of-vector, so a last-word transfer
  // and a load on the same edge restart at element 0 and stay in SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (load_fire) begin
      state_d = SEND;
      idx_d   = '0;
    end else if (out_fire) begin
      if (last_word) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Outputs. valid and data come from registers only. load_ready also
  // opens on the last-word transfer so vectors can run back to back.
  always_comb begin
    output_valid = (state_q == SEND);
    output_data  = buf_q[idx_q];
    load_ready   = (state_q == IDLE) || (out_fire && last_word);
  end

  // Result buffer: saturate and capture the whole vector on a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < N; e++) begin
        buf_q[e] <= '0;
      end
    end else if (load_fire) begin
      for (int e = 0; e < N; e++) begin
        buf_q[e] <= saturate(load_data[e*ACCW +: ACCW]);
      end
    end
  end

endmodule

// File: tb/tb_fc_out_serializer.sv
// Testbench for fc_out_serializer (T=16, N=8, ACCW=36). Inputs are driven on
// the falling edge. Outputs are sampled 1 time unit later, before the next
// rising edge. The expected values for the directed scenarios are constants.
// For the random stress test, a clamp-by-arithmetic model feeds the expected
// queue.
module tb_fc_out_serializer;
  localparam int T    = 16;
  localparam int N    = 8;
  localparam int ACCW = 36;

  logic              clk;
  logic              reset_n;
  logic              load_valid;
  logic              load_ready;
  logic [N*ACCW-1:0] load_data;
  logic              output_valid;
  logic              output_ready;
  logic [T-1:0]      output_data;

  int total;
  int bad;

  longint       vec [N];
  logic [T-1:0] exp_q [$];

  fc_out_serializer #(.T(T), .N(N), .ACCW(ACCW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_reset();
    reset_n      = 1'b0;
    load_valid   = 1'b0;
    output_ready = 1'b0;
    load_data    = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // reference model: clamp to the signed T-bit range, then optional ReLU
  function automatic logic [T-1:0] model(input longint v);
    longint hi;
    longint lo;
    longint r;
    hi = (64'sd1 <<< (T - 1)) - 1;
    lo = -(64'sd1 <<< (T - 1));
    r  = (v > hi) ? hi : ((v < lo) ? lo : v);
`ifdef FC_OUT_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[T-1:0];
  endfunction

  // driver: place vec on load_data and raise load_valid
  task automatic drive_load();
    for (int e = 0; e < N; e++) begin
      load_data[e*ACCW +: ACCW] = vec[e][ACCW-1:0];
    end
    load_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load_valid = 1'b0;
    output_ready = 1'b0;
    load_data = '0;
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", output_valid); end
    total++; if (output_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0000", output_data); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b want=1", load_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [T-1:0] want [N];
`ifdef FC_OUT_RELU_EN
    want = '{16'h0000, 16'h0001, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000};
`else
    want = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFB};
`endif
    vec = '{0, 1, -1, 32767, 32768, -32769, 100000, -5};
    drive_load();
    output_ready = 1'b1;
    #1;
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL sat_load_ready got=%b want=1", load_ready); end
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      #1;
      total++; if (output_valid !== 1'b1) begin bad++; $display("FAIL sat_valid[%0d] got=%b want=1", i, output_valid); end
      total++; if (output_data !== want[i]) begin bad++; $display("FAIL sat_data[%0d] got=%h want=%h", i, output_data, want[i]); end
      @(negedge clk);
    end
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL sat_end_valid got=%b want=0", output_valid); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    for (int e = 0; e < N; e++) vec[e] = 10 + e;
    drive_load();
    output_ready = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (output_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", c, output_valid); end
      total++; if (output_data !== 16'd10) begin bad++; $display("FAIL bp_hold_data[%0d] got=%0d want=10", c, output_data); end
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL bp_load_ready[%0d] got=%b want=0", c, load_ready); end
      @(negedge clk);
    end
    output_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1;
      total++; if (output_valid !== 1'b1 || output_data !== T'(10 + i)) begin
        bad++; $display("FAIL bp_drain[%0d] got=%b/%0d want=1/%0d", i, output_valid, output_data, 10 + i);
      end
      @(negedge clk);
    end
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b want=0", output_valid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [T-1:0] want;
    for (int e = 0; e < N; e++) vec[e] = e + 1;
    drive_load();
    output_ready = 1'b1;
    #1;
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL b2b_a_ready got=%b want=1", load_ready); end
    @(negedge clk);
    for (int e = 0; e < N; e++) vec[e] = -(e + 1);
    drive_load();
    for (int k = 0; k < 2 * N; k++) begin
      #1;
      want = (k < N) ? T'(k + 1) : T'(-(k - N + 1));
      total++; if (output_valid !== 1'b1 || output_data !== want) begin
        bad++; $display("FAIL b2b_word[%0d] got=%b/%h want=1/%h", k, output_valid, output_data, want);
      end
      if (k < N) begin
        total++; if (load_ready !== (k == N - 1)) begin
          bad++; $display("FAIL b2b_load_ready[%0d] got=%b want=%b", k, load_ready, (k == N - 1));
        end
      end
      @(negedge clk);
      if (k == N - 1) load_valid = 1'b0;
    end
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b want=0", output_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e < N; e++) vec[e] = 100 + e;
    drive_load();
    output_ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (output_data !== 16'd103) begin bad++; $display("FAIL rm_pre_data got=%0d want=103", output_data); end
    #1 reset_n = 1'b0;
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", output_valid); end
    total++; if (output_data !== '0) begin bad++; $display("FAIL rm_data got=%h want=0", output_data); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL rm_load_ready got=%b want=1", load_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL rm_post_valid got=%b want=0", output_valid); end
    @(negedge clk);
    for (int e = 0; e < N; e++) vec[e] = 7 + e;
    drive_load();
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      #1;
      total++; if (output_valid !== 1'b1 || output_data !== T'(7 + i)) begin
        bad++; $display("FAIL rm_new[%0d] got=%b/%0d want=1/%0d", i, output_valid, output_data, 7 + i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int sent, got, cycles;
    bit taken, stall_prev;
    logic [T-1:0] held, want;
    longint x;
    sent = 0; got = 0; cycles = 0; taken = 0; stall_prev = 0; held = '0;
    exp_q.delete();
    while (got < 1000 * N && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      if (taken) begin load_valid = 1'b0; taken = 0; end
      if (!load_valid && sent < 1000 && $urandom_range(1) == 1) begin
        for (int e = 0; e < N; e++) begin
          if ($urandom_range(1) == 1) begin
            x = longint'($urandom_range(80000)) - 40000;
          end else begin
            x = longint'({$urandom(), $urandom()});
            x = (x <<< (64 - ACCW)) >>> (64 - ACCW);
          end
          vec[e] = x;
        end
        drive_load();
      end
      output_ready = ($urandom_range(1) == 1);
      #1;
      if (stall_prev) begin
        total++; if (output_valid !== 1'b1 || output_data !== held) begin
          bad++; $display("FAIL rnd_stall_stable got=%b/%h want=1/%h", output_valid, output_data, held);
        end
      end
      stall_prev = output_valid && !output_ready;
      held = output_data;
      if (output_valid && output_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_extra_word got=%h want=none", output_data);
        end else begin
          want = exp_q.pop_front();
          if (output_data !== want) begin
            bad++; $display("FAIL rnd_word[%0d] got=%h want=%h", got, output_data, want);
          end
        end
        got++;
      end
      if (load_valid && load_ready) begin
        for (int e = 0; e < N; e++) exp_q.push_back(model(vec[e]));
        sent++;
        taken = 1;
      end
    end
    @(negedge clk);
    if (taken) load_valid = 1'b0;
    output_ready = 1'b0;
    #1;
    total++; if (got !== 1000 * N) begin bad++; $display("FAIL rnd_word_count got=%0d want=%0d", got, 1000 * N); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_leftover got=%0d want=0", exp_q.size()); end
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL rnd_end_valid got=%b want=0", output_valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    apply_reset();
    test_reset();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
